// File: rtl/calib_seq_if.sv
// Handshake bundle between the command decoder / calibrators and calib_seq_ctrl.
interface calib_seq_if #(
  parameter int CNT_COL = 4
);
  logic               start;
  logic               abort;
  logic               skip_pixel;
  logic               finish_dly_calib;
  logic               pixel_done;
  logic               rst_dly;
  logic               cs_dly_calib;
  logic               cs_pixel_calib;
  logic [CNT_COL-1:0] col_sel;
  logic               busy;
  logic               done;
  logic               err;
  logic [2:0]         state_o;

  modport master (
    output start, abort, skip_pixel, finish_dly_calib, pixel_done,
    input  rst_dly, cs_dly_calib, cs_pixel_calib, col_sel, busy, done, err, state_o
  );

  modport slave (
    input  start, abort, skip_pixel, finish_dly_calib, pixel_done,
    output rst_dly, cs_dly_calib, cs_pixel_calib, col_sel, busy, done, err, state_o
  );
endinterface

// File: rtl/calib_seq_ctrl.sv
// TDC array calibration sequencer: delay-line reset/calib, settle, then per-column pixel calib.
// IDLE 0 | RST_DLY 1 | DLY_CAL 2 | SETTLE 3 | PIX_CAL 4 | PIX_NEXT 5 | DONE 6 | ERR 7
module calib_seq_ctrl #(
  parameter int NUM_COL       = 16,
  parameter int CNT_COL       = 4,
  parameter int RST_PULSE_CYC = 4,
  parameter int SETTLE_CYC    = 8,
  parameter int TO_BITS       = 10,
  parameter int TIMEOUT_CYC   = 1023
) (
  input logic        clk_div_enable,
  input logic        rst_n,
  calib_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RST_DLY  = 3'd1,
    S_DLY_CAL  = 3'd2,
    S_SETTLE   = 3'd3,
    S_PIX_CAL  = 3'd4,
    S_PIX_NEXT = 3'd5,
    S_DONE     = 3'd6,
    S_ERR      = 3'd7
  } state_e;

  localparam logic [TO_BITS-1:0] RST_LOAD    = TO_BITS'(RST_PULSE_CYC - 1);
  localparam logic [TO_BITS-1:0] SETTLE_LOAD = TO_BITS'(SETTLE_CYC - 1);
  localparam logic [TO_BITS-1:0] TO_LOAD     = TO_BITS'(TIMEOUT_CYC - 1);
  localparam logic [CNT_COL-1:0] LAST_COL    = CNT_COL'(NUM_COL - 1);

  state_e             state_q, state_d;
  logic [TO_BITS-1:0] cnt_q, cnt_d;
  logic [CNT_COL-1:0] col_sel_q, col_sel_d;
  logic               skip_q, skip_d;
  logic               err_q, err_d;
  logic               rst_dly_q, rst_dly_d;
  logic               cs_dly_q, cs_dly_d;
  logic               cs_pix_q, cs_pix_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               cnt_tc;
  logic               accept;

  assign cnt_tc = (cnt_q == '0);

  always_ff @(posedge clk_div_enable) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // abort outranks every other transition out of a non-idle state
  always_comb begin
    state_d = state_q;
    if (state_q != S_IDLE && bus.abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:     if (bus.start && !bus.abort) state_d = S_RST_DLY;
        S_RST_DLY:  if (cnt_tc) state_d = S_DLY_CAL;
        S_DLY_CAL: begin
          if (bus.finish_dly_calib) state_d = S_SETTLE;
          else if (cnt_tc)          state_d = S_ERR;
        end
        S_SETTLE:   if (cnt_tc) state_d = skip_q ? S_DONE : S_PIX_CAL;
        S_PIX_CAL: begin
          if (bus.pixel_done) state_d = (col_sel_q == LAST_COL) ? S_DONE : S_PIX_NEXT;
          else if (cnt_tc)    state_d = S_ERR;
        end
        S_PIX_NEXT: state_d = S_PIX_CAL;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they register together with it
  always_comb begin
    accept    = (state_q == S_IDLE) && (state_d == S_RST_DLY);
    cnt_d     = cnt_q;
    col_sel_d = col_sel_q;
    skip_d    = skip_q;
    err_d     = err_q;
    if (state_d != state_q) begin
      case (state_d)
        S_RST_DLY:            cnt_d = RST_LOAD;
        S_SETTLE:             cnt_d = SETTLE_LOAD;
        S_DLY_CAL, S_PIX_CAL: cnt_d = TO_LOAD;
        default:              cnt_d = '0;
      endcase
    end else if (!cnt_tc) begin
      cnt_d = cnt_q - 1'b1;
    end
    if (accept) begin
      col_sel_d = '0;
      skip_d    = bus.skip_pixel;
      err_d     = 1'b0;
    end
    if (state_q == S_PIX_CAL && state_d == S_PIX_NEXT) col_sel_d = col_sel_q + 1'b1;
    if (state_d == S_ERR) err_d = 1'b1;
    rst_dly_d = (state_d == S_RST_DLY);
    cs_dly_d  = (state_d == S_DLY_CAL);
    cs_pix_d  = (state_d == S_PIX_CAL);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk_div_enable) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      col_sel_q <= '0;
      skip_q    <= 1'b0;
      err_q     <= 1'b0;
      rst_dly_q <= 1'b0;
      cs_dly_q  <= 1'b0;
      cs_pix_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      col_sel_q <= col_sel_d;
      skip_q    <= skip_d;
      err_q     <= err_d;
      rst_dly_q <= rst_dly_d;
      cs_dly_q  <= cs_dly_d;
      cs_pix_q  <= cs_pix_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.rst_dly        = rst_dly_q;
  assign bus.cs_dly_calib   = cs_dly_q;
  assign bus.cs_pixel_calib = cs_pix_q;
  assign bus.col_sel        = col_sel_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.err            = err_q;
  assign bus.state_o        = state_q;

endmodule

// File: tb/tb_calib_seq_ctrl.sv
// Bench for calib_seq_ctrl: directed scenarios plus random traffic against a sequence model.
module tb_calib_seq_ctrl;
  localparam int NUM_COL = 16;
  localparam int RST_CYC = 4;
  localparam int SET_CYC = 8;
  localparam int TO_CYC  = 1023;

  logic clk;
  logic rst_n;
  calib_seq_if #(.CNT_COL(4)) bus ();

  calib_seq_ctrl dut (
    .clk_div_enable(clk),
    .rst_n         (rst_n),
    .bus           (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Sequence model: phase number, cycles spent in phase, current column, sticky error.
  int m_st = 0;
  int m_n = 0;
  int m_col = 0;
  bit m_skip = 0;
  bit m_err = 0;

  always @(posedge clk) begin
    int nxt;
    if (!rst_n) begin
      m_st = 0; m_n = 0; m_col = 0; m_skip = 0; m_err = 0;
    end else begin
      nxt = m_st;
      m_n = m_n + 1;
      if (m_st != 0 && bus.abort) nxt = 0;
      else begin
        case (m_st)
          0: if (bus.start && !bus.abort) begin
               nxt = 1; m_skip = bus.skip_pixel; m_err = 0; m_col = 0;
             end
          1: if (m_n == RST_CYC) nxt = 2;
          2: if (bus.finish_dly_calib) nxt = 3; else if (m_n == TO_CYC) nxt = 7;
          3: if (m_n == SET_CYC) nxt = m_skip ? 6 : 4;
          4: if (bus.pixel_done) begin
               if (m_col == NUM_COL - 1) nxt = 6;
               else begin nxt = 5; m_col = m_col + 1; end
             end else if (m_n == TO_CYC) nxt = 7;
          default: nxt = (m_st == 5) ? 4 : 0;
        endcase
      end
      if (nxt == 7) m_err = 1;
      if (nxt != m_st) m_n = 0;
      m_st = nxt;
    end
  end

  function automatic int exp_vec();
    return {m_st[2:0], m_col[3:0], m_st != 0, m_st == 6, m_err, m_st == 1, m_st == 2, m_st == 4};
  endfunction

  function automatic int dut_vec();
    return {bus.state_o, bus.col_sel, bus.busy, bus.done, bus.err,
            bus.rst_dly, bus.cs_dly_calib, bus.cs_pixel_calib};
  endfunction

  bit cmp_en = 0;
  always @(negedge clk) if (cmp_en) chk("outputs{st,col,busy,done,err,rst,csd,csp}", dut_vec(), exp_vec());

  // Calibrator responders: respond after a programmed number of enable cycles.
  int dly_lat = 30;
  int pix_lat[NUM_COL];
  bit noise_en = 0;
  int rc_dly = 0;
  int rc_pix = 0;

  always @(negedge clk) begin
    rc_dly = bus.cs_dly_calib ? rc_dly + 1 : 0;
    rc_pix = bus.cs_pixel_calib ? rc_pix + 1 : 0;
    if (bus.cs_dly_calib) bus.finish_dly_calib = (rc_dly >= dly_lat);
    else bus.finish_dly_calib = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
    if (bus.cs_pixel_calib) bus.pixel_done = (rc_pix >= pix_lat[bus.col_sel]);
    else bus.pixel_done = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  int c_rst, c_dly, c_pix, c_done, c_busy;

  task automatic pulse_start(input bit skp);
    @(negedge clk);
    bus.start = 1'b1; bus.skip_pixel = skp;
    @(negedge clk);
    bus.start = 1'b0; bus.skip_pixel = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    c_rst = 0; c_dly = 0; c_pix = 0; c_done = 0; c_busy = 0;
    while (m_st != 0 && n < budget) begin
      c_rst  += int'(m_st == 1);
      c_dly  += int'(m_st == 2);
      c_pix  += int'(m_st == 4);
      c_done += int'(m_st == 6);
      c_busy += 1;
      @(negedge clk);
      n++;
    end
    chk({tag, "_finished_in_budget"}, int'(m_st == 0), 1);
  endtask

  task automatic set_pix(input int v);
    for (int i = 0; i < NUM_COL; i++) pix_lat[i] = v;
  endtask

  int guard;
  int n_done;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 0; bus.abort = 0; bus.skip_pixel = 0; rst_n = 0;
    set_pix(5);
    repeat (3) @(negedge clk);
    chk("reset_vec", dut_vec(), 0);
    chk("reset_state", int'(bus.state_o), 0);
    cmp_en = 1;
    rst_n = 1;
    repeat (2) @(negedge clk);

    // nominal full sequence
    dly_lat = 30; set_pix(5);
    pulse_start(0);
    wait_idle(3000, "nominal");
    chk("nom_rst_cycles", c_rst, 4);
    chk("nom_dly_cycles", c_dly, 30);
    chk("nom_pix_cycles", c_pix, 80);
    chk("nom_done_pulses", c_done, 1);
    chk("nom_busy_cycles", c_busy, 138);
    chk("nom_err", int'(bus.err), 0);

    // delay calibration only
    pulse_start(1);
    wait_idle(3000, "skip");
    chk("skip_pix_cycles", c_pix, 0);
    chk("skip_done_pulses", c_done, 1);
    chk("skip_busy_cycles", c_busy, 43);

    // delay-calibrator timeout
    dly_lat = 5000;
    pulse_start(0);
    wait_idle(3000, "dly_timeout");
    chk("to_dly_cycles", c_dly, 1023);
    chk("to_done_pulses", c_done, 0);
    chk("to_busy_cycles", c_busy, 1028);
    repeat (3) @(negedge clk);
    chk("to_err_sticky", int'(bus.err), 1);
    dly_lat = 10;
    pulse_start(1);
    chk("to_err_cleared_by_start", int'(bus.err), 0);
    wait_idle(3000, "after_timeout");

    // response on the last permitted timeout cycle wins
    dly_lat = 12; set_pix(3); pix_lat[7] = 1023;
    pulse_start(0);
    wait_idle(4000, "race");
    chk("race_pix_cycles", c_pix, 15 * 3 + 1023);
    chk("race_done_pulses", c_done, 1);
    chk("race_err", int'(m_err), 0);

    // abort in column 3
    dly_lat = 8; set_pix(5);
    pulse_start(0);
    guard = 0;
    while (!(m_st == 4 && m_col == 3) && guard < 2000) begin @(negedge clk); guard++; end
    chk("abort_reached_col3", int'(m_st == 4 && m_col == 3), 1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_state", int'(bus.state_o), 0);
    chk("abort_strobes", int'({bus.rst_dly, bus.cs_dly_calib, bus.cs_pixel_calib, bus.done}), 0);
    chk("abort_err", int'(bus.err), 0);
    pulse_start(0);
    guard = 0;
    while (m_st != 4 && guard < 2000) begin @(negedge clk); guard++; end
    chk("restart_col_sel", int'(bus.col_sel), 0);
    wait_idle(3000, "restart");
    // start together with abort in IDLE is ignored
    @(negedge clk);
    bus.start = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    chk("start_with_abort_idle", int'(bus.busy), 0);

    // start while busy neither restarts nor re-latches skip
    dly_lat = 30;
    pulse_start(1);
    repeat (10) @(negedge clk);
    pulse_start(0);
    wait_idle(3000, "start_busy");
    chk("start_busy_pix_cycles", c_pix, 0);
    chk("start_busy_done", c_done, 1);

    // synchronous reset mid delay calibration
    pulse_start(0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_vec", dut_vec(), 0);
    repeat (3) @(negedge clk);

    // random traffic
    noise_en = 1;
    n_done = 0;
    for (int i = 0; i < 9000; i++) begin
      @(negedge clk);
      if (m_st == 6) n_done++;
      if (m_st == 0) begin
        dly_lat = ($urandom_range(0, 9) == 0) ? $urandom_range(1020, 1026) : $urandom_range(1, 40);
        for (int c = 0; c < NUM_COL; c++) pix_lat[c] = $urandom_range(1, 8);
      end
      rst_n = ($urandom_range(0, 1999) != 0);
      bus.abort = ($urandom_range(0, 299) == 0);
      bus.start = ($urandom_range(0, 29) == 0);
      bus.skip_pixel = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    rst_n = 1; bus.abort = 0; bus.start = 0; noise_en = 0;
    chk("random_sequences_completed", int'(n_done > 0), 1);
    repeat (5) @(negedge clk);
    cmp_en = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
